// File: rtl/aes_pkg.sv
// Shared AES helpers: legal state widths, ShiftRows row offsets, byte indexing
// and the elaboration-time parameter check used by the pipelined stage.
package aes_pkg;

   localparam int unsigned NbLegal [3] = '{4, 6, 8};
   localparam int unsigned LatMin      = 1;
   localparam int unsigned LatMax      = 4;

   function automatic bit nb_legal(input int unsigned nb);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (nb == NbLegal[i]) ok = 1'b1;
      end
      return ok;
   endfunction

   // Rijndael with 8 columns skips offset 2 on the upper rows.
   function automatic int unsigned sr_offset(input int unsigned nb, input int unsigned r);
      return (nb == 8 && r >= 2) ? r + 1 : r;
   endfunction

   function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
      return r + 4 * c;
   endfunction

   function automatic bit params_ok(input int unsigned nb, input int unsigned lat);
      return nb_legal(nb) && (lat >= LatMin) && (lat <= LatMax);
   endfunction

endpackage

// File: rtl/shift_rows_pipe_stage.sv
// One register slice of the ShiftRows pipeline: valid, mode bit and state.
// Contents are replaced only when the slice is loaded with a valid block.
module shift_rows_pipe_stage
   import aes_pkg::*;
#(
   parameter int unsigned W = 128
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic         valid_i,
   input  logic         inv_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic         inv_o,
   output logic [W-1:0] data_o
);

   logic         valid_d, valid_q;
   logic         inv_d, inv_q;
   logic [W-1:0] data_d, data_q;

   always_comb begin
      valid_d = valid_q;
      inv_d   = inv_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = valid_i;
         // Bubbles leave the payload alone so idle outputs do not toggle.
         if (valid_i) begin
            inv_d  = inv_i;
            data_d = data_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         inv_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         inv_q   <= inv_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign inv_o   = inv_q;
   assign data_o  = data_q;

endmodule

// File: rtl/shift_rows_pipe.sv
// Pipelined ShiftRows / InvShiftRows with valid/ready flow control, collapsing
// bubbles and an in-flight block count.
module shift_rows_pipe
   import aes_pkg::*;
#(
   parameter  int unsigned NB   = 4,
   parameter  int unsigned LAT  = 1,
   localparam int unsigned W    = 32 * NB,
   localparam int unsigned OccW = $clog2(LAT + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_inv,
   input  logic [W-1:0]    in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_inv,
   output logic [W-1:0]    out_data,
   output logic [OccW-1:0] occupancy
);

   if (!params_ok(NB, LAT)) begin : g_param_err
      $error("shift_rows_pipe: illegal NB or LAT");
   end

   logic [W-1:0] fwd_data, inv_data, perm_data;

   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int unsigned H    = sr_offset(NB, r);
         localparam int unsigned Dst  = byte_idx(r, c);
         localparam int unsigned SrcF = byte_idx(r, (c + H) % NB);
         localparam int unsigned SrcI = byte_idx(r, (c + NB - H) % NB);
         assign fwd_data[8*Dst +: 8] = in_data[8*SrcF +: 8];
         assign inv_data[8*Dst +: 8] = in_data[8*SrcI +: 8];
      end
   end

   assign perm_data = in_inv ? inv_data : fwd_data;

   logic [LAT-1:0] st_valid, st_inv, st_load;
   logic [W-1:0]   st_data [LAT];

   // A slice may load when empty or when the slice after it loads this cycle.
   always_comb begin
      st_load          = '0;
      st_load[LAT-1]   = !st_valid[LAT-1] || out_ready;
      for (int i = int'(LAT) - 2; i >= 0; i--) begin
         st_load[i] = !st_valid[i] || st_load[i+1];
      end
   end

   for (genvar i = 0; i < LAT; i++) begin : g_stage
      logic         up_valid, up_inv;
      logic [W-1:0] up_data;

      if (i == 0) begin : g_first
         assign up_valid = in_valid;
         assign up_inv   = in_inv;
         assign up_data  = perm_data;
      end else begin : g_next
         assign up_valid = st_valid[i-1];
         assign up_inv   = st_inv[i-1];
         assign up_data  = st_data[i-1];
      end

      shift_rows_pipe_stage #(
         .W (W)
      ) u_stage (
         .clk_i   (clk),
         .rst_i   (rst),
         .load_i  (st_load[i]),
         .valid_i (up_valid),
         .inv_i   (up_inv),
         .data_i  (up_data),
         .valid_o (st_valid[i]),
         .inv_o   (st_inv[i]),
         .data_o  (st_data[i])
      );
   end

   assign in_ready  = st_load[0] && !rst;
   assign out_valid = st_valid[LAT-1];
   assign out_inv   = st_inv[LAT-1];
   assign out_data  = st_data[LAT-1];

   logic            accept, out_hs;
   logic [OccW-1:0] occ_d, occ_q;

   assign accept = in_valid && in_ready;
   assign out_hs = out_valid && out_ready;

   always_comb begin
      occ_d = occ_q;
      if (accept && !out_hs) begin
         occ_d = occ_q + OccW'(1);
      end else if (out_hs && !accept) begin
         occ_d = occ_q - OccW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench: NB=4 vector table through a LAT=1 pipe, NB=8 routing, LAT=2
// backpressure and reset, LAT=3 streaming latency and occupancy.
module tb_shift_rows_pipe;

   logic clk;
   logic rst;
   logic in_valid, in_inv, out_ready;
   logic [127:0] in_data4;
   logic [255:0] in_data8;

   logic rdy1, ov1, oi1; logic [127:0] od1; logic [0:0] occ1;
   logic rdy2, ov2, oi2; logic [127:0] od2; logic [1:0] occ2;
   logic rdy3, ov3, oi3; logic [127:0] od3; logic [1:0] occ3;
   logic rdy8, ov8, oi8; logic [255:0] od8; logic [0:0] occ8;

   int n_tests = 0;
   int n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   shift_rows_pipe #(.NB(4), .LAT(1)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_inv(in_inv),
      .in_data(in_data4), .out_valid(ov1), .out_ready(out_ready), .out_inv(oi1),
      .out_data(od1), .occupancy(occ1));

   shift_rows_pipe #(.NB(4), .LAT(2)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_inv(in_inv),
      .in_data(in_data4), .out_valid(ov2), .out_ready(out_ready), .out_inv(oi2),
      .out_data(od2), .occupancy(occ2));

   shift_rows_pipe #(.NB(4), .LAT(3)) u_d3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .in_inv(in_inv),
      .in_data(in_data4), .out_valid(ov3), .out_ready(out_ready), .out_inv(oi3),
      .out_data(od3), .occupancy(occ3));

   shift_rows_pipe #(.NB(8), .LAT(1)) u_d8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_inv(in_inv),
      .in_data(in_data8), .out_valid(ov8), .out_ready(out_ready), .out_inv(oi8),
      .out_data(od8), .occupancy(occ8));

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic         inv;
      logic [127:0] din;
      logic [127:0] dout;
   } vec_t;

   localparam int NumVec = 9;
   vec_t vecs [NumVec];

   logic [127:0] orig4, v1out, v3out, exp_a, exp_b, exp_c;
   logic [255:0] orig8, fwd8;
   logic [31:0]  w;

   initial begin
      orig4 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
      v1out = 128'h0b06010c_07020d08_030e0904_0f0a0500;
      v3out = 128'h0306090c_0f020508_0b0e0104_070a0d00;
      vecs[0] = '{1'b0, orig4, v1out};
      vecs[1] = '{1'b1, v1out, orig4};
      vecs[2] = '{1'b1, orig4, v3out};
      vecs[3] = '{1'b0, v3out, orig4};
      vecs[4] = '{1'b0, 128'h0, 128'h0};
      vecs[5] = '{1'b1, {128{1'b1}}, {128{1'b1}}};
      vecs[6] = '{1'b0, {4{32'h33221100}}, {4{32'h33221100}}};
      vecs[7] = '{1'b0, 128'h0000_0000_0000_0000_0000_aa00_0000_0000,
                  128'h0000_0000_0000_0000_0000_0000_0000_aa00};
      vecs[8] = '{1'b1, 128'h0000_0000_0000_0000_0000_aa00_0000_0000,
                  128'h0000_0000_0000_aa00_0000_0000_0000_0000};

      rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0;
      in_data4 = '0; in_data8 = '0;
      tick();
      tick();
      check("rst_in_ready_low", 256'(rdy1), 256'h0);
      check("rst_in_ready_low_l2", 256'(rdy2), 256'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 256'(rdy1), 256'h1);
      check("post_rst_out_valid", 256'(ov1), 256'h0);
      check("post_rst_out_data", 256'(od1), 256'h0);
      check("post_rst_out_inv", 256'(oi1), 256'h0);
      check("post_rst_occ", 256'(occ3), 256'h0);

      // Back-to-back table through the LAT=1 pipe, modes alternating.
      out_ready = 1'b1;
      for (int i = 0; i < NumVec; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_inv   = vecs[i].inv;
         in_data4 = vecs[i].din;
         tick();
         check($sformatf("vec%0d_valid", i), 256'(ov1), 256'h1);
         check($sformatf("vec%0d_data", i), 256'(od1), 256'(vecs[i].dout));
         check($sformatf("vec%0d_inv", i), 256'(oi1), 256'(vecs[i].inv));
      end

      // NB=8 routing and round trip.
      for (int k = 0; k < 32; k++) orig8[8*k +: 8] = 8'(k);
      @(negedge clk);
      in_inv = 1'b0; in_data8 = orig8;
      tick();
      fwd8 = od8;
      check("nb8_valid", 256'(ov8), 256'h1);
      check("nb8_byte1", 256'(fwd8[15:8]), 256'h05);
      check("nb8_byte2", 256'(fwd8[23:16]), 256'h0e);
      check("nb8_byte3", 256'(fwd8[31:24]), 256'h13);
      check("nb8_byte30", 256'(fwd8[247:240]), 256'h0a);
      check("nb8_byte31", 256'(fwd8[255:248]), 256'h0f);
      @(negedge clk);
      in_inv = 1'b1; in_data8 = fwd8;
      tick();
      check("nb8_roundtrip", od8, orig8);
      check("nb8_roundtrip_inv", 256'(oi8), 256'h1);

      // LAT=2 backpressure with three blocks offered.
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      tick();
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b0;
      exp_a = vecs[0].dout; exp_b = vecs[2].dout; exp_c = vecs[7].dout;
      @(negedge clk);
      in_valid = 1'b1; in_inv = 1'b0; in_data4 = vecs[0].din;
      #1 check("bp_a_ready", 256'(rdy2), 256'h1);
      tick();
      @(negedge clk);
      in_inv = 1'b1; in_data4 = vecs[2].din;
      #1 check("bp_b_ready", 256'(rdy2), 256'h1);
      tick();
      check("bp_full_occ", 256'(occ2), 256'h2);
      check("bp_full_valid", 256'(ov2), 256'h1);
      check("bp_full_data", 256'(od2), 256'(exp_a));
      @(negedge clk);
      in_inv = 1'b0; in_data4 = vecs[7].din;
      #1 check("bp_full_ready_low", 256'(rdy2), 256'h0);
      tick();
      check("bp_hold_data", 256'(od2), 256'(exp_a));
      check("bp_hold_inv", 256'(oi2), 256'h0);
      check("bp_hold_occ", 256'(occ2), 256'h2);
      @(negedge clk);
      out_ready = 1'b1;
      #1 check("bp_passthru_ready", 256'(rdy2), 256'h1);
      tick();
      check("bp_out_b_data", 256'(od2), 256'(exp_b));
      check("bp_out_b_inv", 256'(oi2), 256'h1);
      check("bp_out_b_occ", 256'(occ2), 256'h2);
      @(negedge clk);
      in_valid = 1'b0;
      tick();
      check("bp_out_c_valid", 256'(ov2), 256'h1);
      check("bp_out_c_data", 256'(od2), 256'(exp_c));
      check("bp_out_c_occ", 256'(occ2), 256'h1);
      tick();
      check("bp_drained_valid", 256'(ov2), 256'h0);
      check("bp_drained_occ", 256'(occ2), 256'h0);

      // Reset with two blocks in flight.
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0; in_data4 = vecs[0].din;
      tick();
      @(negedge clk);
      in_data4 = vecs[2].din;
      tick();
      check("mid_rst_pre_occ", 256'(occ2), 256'h2);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      #1 check("mid_rst_ready_low", 256'(rdy2), 256'h0);
      tick();
      check("mid_rst_valid", 256'(ov2), 256'h0);
      check("mid_rst_occ", 256'(occ2), 256'h0);
      check("mid_rst_data", 256'(od2), 256'h0);
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("mid_rst_no_stale%0d", k), 256'(ov2), 256'h0);
      end

      // LAT=3 streaming; column-uniform states are fixed points of both modes.
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         w = 32'h10203040 + 32'(k) * 32'h01010101;
         in_valid = 1'b1; in_inv = k[0]; in_data4 = {4{w}};
         #1 check($sformatf("lat3_ready%0d", k), 256'(rdy3), 256'h1);
         tick();
         check($sformatf("lat3_occ%0d", k), 256'(occ3), 256'((k < 2) ? k + 1 : 3));
         if (k < 2) begin
            check($sformatf("lat3_empty%0d", k), 256'(ov3), 256'h0);
         end else begin
            w = 32'h10203040 + 32'(k - 2) * 32'h01010101;
            check($sformatf("lat3_valid%0d", k), 256'(ov3), 256'h1);
            check($sformatf("lat3_data%0d", k), 256'(od3), 256'({4{w}}));
            check($sformatf("lat3_inv%0d", k), 256'(oi3), 256'(k[0]));
         end
      end
      @(negedge clk);
      in_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_rows_pipe.md
# shift_rows_pipe

Parametrised, pipelined AES/Rijndael ShiftRows stage with a valid/ready handshake. It supports block widths of Nb = 4, 6 or 8 columns, and selects forward ShiftRows or InvShiftRows per block. It sits in the round datapath between SubBytes and MixColumns and replaces the fixed 128-bit combinational permutation. It adds backpressure, configurable latency and an in-flight occupancy count.

## Interface
- NB, 4, state columns; legal values 4, 6, 8; any other value is an elaboration error.
- LAT, 1, pipeline register stages; legal range 1..4.
- W, 32*NB, derived data width; not overridable.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input block present.
- in_ready  out  1  block accepted this cycle when in_valid && in_ready.
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled with in_data.
- in_data  in  W  input state.
- out_valid  out  1  output block present.
- out_ready  in  1  downstream accepts.
- out_inv  out  1  mode bit travelling with the block.
- out_data  out  W  permuted state.
- occupancy  out  $clog2(LAT+1)  blocks currently held in the pipeline.

## Operation
- Byte map: state byte s[r][c] (r = 0..3, c = 0..NB-1) occupies bits [8k+7:8k], where k = r + 4c. Byte s[0][0] is the LSB.
- Row offsets h(r):
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Forward: out[r][c] = in[r][(c + h(r)) mod NB].
- Inverse: out[r][c] = in[r][(c − h(r)) mod NB].
- The permutation is purely byte routing, with no arithmetic on data. It is applied combinationally in front of stage 0. Stages 1..LAT-1 carry data and the mode bit unchanged.
- Each stage holds a valid bit, data and the inv bit. Stage i loads when it is empty or when its contents advance this cycle. The last stage advances when out_ready = 1.
- in_ready = stage-0 load enable. Bubbles collapse, so an empty middle stage never stalls the upstream stages.
- Blocks leave in acceptance order. None are dropped or duplicated.
- occupancy update per cycle: +1 on an accepted input, −1 on an output handshake (out_valid && out_ready). Both in the same cycle leave it unchanged. It never exceeds LAT.

## Timing
- Reset values: all stage valid bits 0, out_valid 0, out_data 0, out_inv 0, occupancy 0. in_ready is 1 in the first cycle after reset is released.
- While rst is high, in_ready = 0.
- Reset mid-operation discards every in-flight block on the next clock edge. No partial output is produced.
- Latency: a block accepted at edge n is presented on out_valid after edge n+LAT-1, i.e. visible in the cycle following edge n+LAT-1.
- Throughput: one block per cycle while out_ready = 1.
- Full pipeline (occupancy = LAT) with out_ready = 0 forces in_ready = 0.
- A full pipeline with out_ready = 1 accepts a new input in the same cycle (pass-through).
- While out_valid = 1 and out_ready = 0, out_data and out_inv hold stable.
- in_ready depends combinationally on out_ready, through at most LAT enable terms. in_data has no combinational path to out_data.

## Structure
- Shared package aes_pkg:
  - legal NB values;
  - function sr_offset(nb, r);
  - function byte_idx(r, c);
  - parameter check.
- Sub-module shift_rows_pipe_stage: one valid/inv/data register slice, with load enable and advance logic. Instantiate it LAT times in a generate loop.
- The permutation stays in the top level as a generate loop over r and c, muxed by in_inv.

## Test plan
- NB=4, LAT=1, in_inv=0, in_data=0x0f0e0d0c_0b0a0908_07060504_03020100. Required: out_data=0x0b06010c_07020d08_030e0904_0f0a0500 one cycle later, with out_inv=0.
- Same NB/LAT, in_inv=1, input = the previous output. Required: out_data=0x0f0e…0100 (original restored) and out_inv=1. Back-to-back alternating modes on consecutive cycles are each correct.
- NB=8, in_inv=0, byte k = k. Required: out byte 2 = 0x0e, out byte 3 = 0x13, out byte 1 = 0x05. The inverse transform of the result recovers the input.
- LAT=2, out_ready=0, three blocks offered. Required: the first two are accepted, then in_ready=0 and occupancy=2, with out_data stable. After out_ready rises, all three emerge in order, one per cycle.
- LAT=3, continuous in_valid and out_ready. Required: first output 3 cycles after the first accept, then one block per cycle, with occupancy steady at 3.
- rst asserted with occupancy=2. Required: next cycle out_valid=0, occupancy=0 and out_data=0; no stale block appears after rst is released.
